// File: rtl/csr_master_agent.sv
// Single-outstanding CSR bus master: turns one host command into one CSR
// request/response transaction and returns read data plus fault/timeout status.
module csr_master_agent #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [1:0]        cmd_priv,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_rdata,
    output logic              res_fault,
    output logic              res_timeout,
    output logic              csr_req_valid,
    input  logic              csr_req_ready,
    output logic              csr_req_write,
    output logic [ADDR_W-1:0] csr_req_addr,
    output logic [DATA_W-1:0] csr_req_wdata,
    output logic [1:0]        csr_req_priv,
    input  logic              csr_rsp_valid,
    output logic              csr_rsp_ready,
    input  logic [DATA_W-1:0] csr_rsp_rdata,
    input  logic              csr_rsp_fault
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The counter reads 0 in the first REQ cycle, so expiry is decided one
    // count early to land DONE exactly TIMEOUT_CYCLES cycles after accept.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        priv_q, priv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic              timeout_q, timeout_d;
    logic              expired;

    assign expired = (cnt_q >= CNT_LAST);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        priv_d    = priv_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        timeout_d = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    priv_d  = cmd_priv;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (csr_req_ready) begin
                    state_d = ST_WAIT;
                end else if (expired) begin
                    rdata_d   = '0;
                    fault_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (csr_rsp_valid) begin
                    rdata_d   = csr_rsp_rdata;
                    fault_d   = csr_rsp_fault;
                    timeout_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (expired) begin
                    rdata_d   = '0;
                    fault_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            priv_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            priv_q    <= priv_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
            timeout_q <= timeout_d;
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign csr_req_valid = (state_q == ST_REQ);
    assign csr_rsp_ready = (state_q != ST_REQ);
    assign res_valid     = (state_q == ST_DONE);
    assign csr_req_write = write_q;
    assign csr_req_addr  = addr_q;
    assign csr_req_wdata = wdata_q;
    assign csr_req_priv  = priv_q;
    assign res_rdata     = rdata_q;
    assign res_fault     = fault_q;
    assign res_timeout   = timeout_q;

endmodule

// File: tb/tb_csr_master_agent.sv
// Bench for csr_master_agent: directed test-plan scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_csr_master_agent;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int T_CYC = 8;
    localparam logic [AW-1:0] TIER_ADDR    = 32'h0000_0100;
    localparam logic [AW-1:0] CAUSE_ADDR   = 32'h0000_0142;
    localparam logic [AW-1:0] SCRATCH_ADDR = 32'h0000_0340;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [1:0]    cmd_priv;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_rdata;
    logic          res_fault, res_timeout;
    logic          csr_req_valid, csr_req_ready, csr_req_write;
    logic [AW-1:0] csr_req_addr;
    logic [DW-1:0] csr_req_wdata;
    logic [1:0]    csr_req_priv;
    logic          csr_rsp_valid, csr_rsp_ready;
    logic [DW-1:0] csr_rsp_rdata;
    logic          csr_rsp_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_master_agent #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_priv(cmd_priv),
        .res_valid(res_valid), .res_ready(res_ready), .res_rdata(res_rdata),
        .res_fault(res_fault), .res_timeout(res_timeout),
        .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
        .csr_req_write(csr_req_write), .csr_req_addr(csr_req_addr),
        .csr_req_wdata(csr_req_wdata), .csr_req_priv(csr_req_priv),
        .csr_rsp_valid(csr_rsp_valid), .csr_rsp_ready(csr_rsp_ready),
        .csr_rsp_rdata(csr_rsp_rdata), .csr_rsp_fault(csr_rsp_fault)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: is a command in flight, has its request been
    // taken, how many cycles since accept, and is a result waiting.
    bit            m_on = 1'b0;
    bit            m_busy, m_req_pend, m_have_res;
    int            m_age;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [1:0]    m_priv;
    logic          m_fault, m_timeout;

    task automatic model_result(input logic [DW-1:0] d, input logic f, input logic t);
        m_rdata    = d;
        m_fault    = f;
        m_timeout  = t;
        m_busy     = 1'b0;
        m_have_res = 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            m_on = 1'b1; m_busy = 1'b0; m_req_pend = 1'b0; m_have_res = 1'b0; m_age = 0;
            m_write = 1'b0; m_addr = '0; m_wdata = '0; m_priv = '0;
            m_rdata = '0; m_fault = 1'b0; m_timeout = 1'b0;
        end else if (m_on) begin
            if (m_have_res) begin
                if (res_ready) m_have_res = 1'b0;
            end else if (!m_busy) begin
                if (cmd_valid) begin
                    m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata; m_priv = cmd_priv;
                    m_busy = 1'b1; m_req_pend = 1'b1; m_age = 1;
                end
            end else begin
                // m_age is the index of the current cycle since accept; expiry
                // in cycle T-1 puts the result out in cycle T.
                if (m_req_pend) begin
                    if (csr_req_ready) m_req_pend = 1'b0;
                    else if (m_age >= T_CYC - 1) model_result('0, 1'b1, 1'b1);
                end else if (csr_rsp_valid) begin
                    model_result(csr_rsp_rdata, csr_rsp_fault, 1'b0);
                end else if (m_age >= T_CYC - 1) begin
                    model_result('0, 1'b1, 1'b1);
                end
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("cmd_ready", 64'(cmd_ready), 64'(!m_busy && !m_have_res));
            check("csr_req_valid", 64'(csr_req_valid), 64'(m_busy && m_req_pend));
            check("csr_rsp_ready", 64'(csr_rsp_ready), 64'(!(m_busy && m_req_pend)));
            check("res_valid", 64'(res_valid), 64'(m_have_res));
            if (m_busy && m_req_pend) begin
                check("csr_req_write", 64'(csr_req_write), 64'(m_write));
                check("csr_req_addr", 64'(csr_req_addr), 64'(m_addr));
                check("csr_req_wdata", 64'(csr_req_wdata), 64'(m_wdata));
                check("csr_req_priv", 64'(csr_req_priv), 64'(m_priv));
            end
            if (m_have_res) begin
                check("res_rdata", 64'(res_rdata), 64'(m_rdata));
                check("res_fault", 64'(res_fault), 64'(m_fault));
                check("res_timeout", 64'(res_timeout), 64'(m_timeout));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for exactly one cycle; returns in cycle 1 after accept.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_priv = 2'd1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    logic [DW-1:0] scratch;

    initial begin
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_priv = '0; res_ready = 1'b0; csr_req_ready = 1'b0; csr_rsp_valid = 1'b0;
        csr_rsp_rdata = '0; csr_rsp_fault = 1'b0;
        tick(); tick();
        rst_n = 1'b0;

        check("rst cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst res_valid", 64'(res_valid), 64'd0);
        check("rst csr_req_valid", 64'(csr_req_valid), 64'd0);
        check("rst res_rdata", 64'(res_rdata), 64'd0);
        check("rst res_fault", 64'(res_fault), 64'd0);
        check("rst csr_req_addr", 64'(csr_req_addr), 64'd0);

        // TIER read, zero-wait target
        csr_req_ready = 1'b1; csr_rsp_valid = 1'b1; csr_rsp_rdata = 32'h2; csr_rsp_fault = 1'b0;
        issue(1'b0, TIER_ADDR, '0);
        check("tier req_valid c1", 64'(csr_req_valid), 64'd1);
        check("tier req_priv", 64'(csr_req_priv), 64'd1);
        check("tier req_addr", 64'(csr_req_addr), 64'(TIER_ADDR));
        tick();
        check("tier res_valid c2", 64'(res_valid), 64'd0);
        tick();
        check("tier res_valid c3", 64'(res_valid), 64'd1);
        check("tier rdata", 64'(res_rdata), 64'h2);
        check("tier fault", 64'(res_fault), 64'd0);
        consume();
        check("tier back idle", 64'(cmd_ready), 64'd1);

        // CAUSE read, result held while res_ready stays low
        csr_rsp_rdata = 32'h1;
        issue(1'b0, CAUSE_ADDR, '0);
        tick(); tick();
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("cause hold valid", 64'(res_valid), 64'd1);
            check("cause hold rdata", 64'(res_rdata), 64'h1);
            check("cause hold cmd_ready", 64'(cmd_ready), 64'd0);
            tick();
        end
        cmd_valid = 1'b0;
        consume();

        // Write scratch then read it back
        issue(1'b1, SCRATCH_ADDR, 32'hDEAD_BEEF);
        check("wr req_write", 64'(csr_req_write), 64'd1);
        check("wr req_wdata", 64'(csr_req_wdata), 64'hDEAD_BEEF);
        scratch = csr_req_wdata;
        csr_rsp_rdata = '0;
        tick(); tick();
        consume();
        csr_rsp_rdata = scratch;
        issue(1'b0, SCRATCH_ADDR, '0);
        check("rd req_write", 64'(csr_req_write), 64'd0);
        tick(); tick();
        check("readback", 64'(res_rdata), 64'hDEAD_BEEF);
        consume();

        // Target fault
        csr_rsp_rdata = '0; csr_rsp_fault = 1'b1;
        issue(1'b0, 32'h0000_0FFF, '0);
        tick(); tick();
        check("tgt fault", 64'(res_fault), 64'd1);
        check("tgt fault timeout", 64'(res_timeout), 64'd0);
        consume();

        // Timeout: target never ready
        csr_req_ready = 1'b0; csr_rsp_valid = 1'b0; csr_rsp_fault = 1'b0;
        issue(1'b0, CAUSE_ADDR, '0);
        for (int c = 2; c <= T_CYC - 1; c++) begin
            tick();
            check("to not yet", 64'(res_valid), 64'd0);
        end
        tick();
        check("to res_valid", 64'(res_valid), 64'd1);
        check("to fault", 64'(res_fault), 64'd1);
        check("to timeout", 64'(res_timeout), 64'd1);
        check("to rdata", 64'(res_rdata), 64'd0);
        csr_rsp_valid = 1'b1; csr_rsp_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        check("late rsp ignored rdata", 64'(res_rdata), 64'd0);
        check("late rsp ignored to", 64'(res_timeout), 64'd1);
        consume();
        tick();
        check("late rsp idle cmd_ready", 64'(cmd_ready), 64'd1);
        check("late rsp idle res_valid", 64'(res_valid), 64'd0);
        csr_rsp_valid = 1'b0;

        // Reset while in WAIT
        csr_req_ready = 1'b1;
        issue(1'b0, TIER_ADDR, '0);
        tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("mid rst cmd_ready", 64'(cmd_ready), 64'd1);
        check("mid rst res_valid", 64'(res_valid), 64'd0);
        check("mid rst req_valid", 64'(csr_req_valid), 64'd0);

        // Randomized traffic, alternating responsive and sluggish target windows
        for (int i = 0; i < 4000; i++) begin
            bit slow;
            slow          = ((i / 400) % 2) == 1;
            rst_n         = ($urandom_range(0, 249) == 0);
            cmd_valid     = $urandom_range(0, 1) == 1;
            cmd_write     = $urandom_range(0, 1) == 1;
            cmd_addr      = $urandom;
            cmd_wdata     = $urandom;
            cmd_priv      = 2'($urandom_range(0, 3));
            res_ready     = $urandom_range(0, 2) != 0;
            csr_req_ready = slow ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
            csr_rsp_valid = slow ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 9) < 5);
            csr_rsp_rdata = $urandom;
            csr_rsp_fault = $urandom_range(0, 3) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
